// File: rtl/motoro3_step_timer.sv
// Step sequencer: splits each electrical period into 12 commutation steps of
// Reff clocks, with step/cycle pulses and a 511-clock pwmSTEP sub-counter.
module motoro3_step_timer (
  input  logic        clk,
  input  logic        nRst,
  input  logic [24:0] m3cnt_reload1,
  input  logic        m3_en,
  input  logic        m3_dir,
  output logic [3:0]  m3step_idx,
  output logic        m3step_pulse,
  output logic        m3cycle_pulse,
  output logic [24:0] m3cnt_now,
  output logic [8:0]  m3pwm_cnt,
  output logic        m3pwm_tick,
  output logic        m3_running
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_STEP = 4'd11;
  localparam logic [8:0] PWM_LAST  = 9'd510;

  state_t      state;
  logic [24:0] reload_m1;
  logic [3:0]  idx_next;
  logic        idx_wrap;
  logic [8:0]  pwm_next;

  // Reff-1 with Reff = max(reload, 2); sampled only at start and boundaries.
  always_comb begin
    reload_m1 = 25'd1;
    if (m3cnt_reload1 >= 25'd2) reload_m1 = m3cnt_reload1 - 25'd1;
  end

  always_comb begin
    idx_wrap = 1'b0;
    idx_next = m3step_idx;
    if (m3_dir) begin
      idx_wrap = (m3step_idx == LAST_STEP);
      idx_next = idx_wrap ? 4'd0 : m3step_idx + 4'd1;
    end else begin
      idx_wrap = (m3step_idx == 4'd0);
      idx_next = idx_wrap ? LAST_STEP : m3step_idx - 4'd1;
    end
  end

  always_comb begin
    pwm_next = (m3pwm_cnt == PWM_LAST) ? 9'd0 : m3pwm_cnt + 9'd1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      m3step_idx    <= 4'd0;
      m3step_pulse  <= 1'b0;
      m3cycle_pulse <= 1'b0;
      m3cnt_now     <= 25'd0;
      m3pwm_cnt     <= 9'd0;
      m3pwm_tick    <= 1'b0;
      m3_running    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m3cycle_pulse <= 1'b0;
          m3step_idx    <= 4'd0;
          m3pwm_cnt     <= 9'd0;
          if (m3_en) begin
            state        <= RUN;
            m3cnt_now    <= reload_m1;
            m3step_pulse <= 1'b1;
            m3pwm_tick   <= 1'b1;
            m3_running   <= 1'b1;
          end else begin
            m3cnt_now    <= 25'd0;
            m3step_pulse <= 1'b0;
            m3pwm_tick   <= 1'b0;
            m3_running   <= 1'b0;
          end
        end
        RUN: begin
          if (!m3_en) begin
            // Stopping discards the partial step; outputs return to reset values.
            state         <= IDLE;
            m3step_idx    <= 4'd0;
            m3step_pulse  <= 1'b0;
            m3cycle_pulse <= 1'b0;
            m3cnt_now     <= 25'd0;
            m3pwm_cnt     <= 9'd0;
            m3pwm_tick    <= 1'b0;
            m3_running    <= 1'b0;
          end else if (m3cnt_now != 25'd0) begin
            m3cnt_now     <= m3cnt_now - 25'd1;
            m3pwm_cnt     <= pwm_next;
            m3pwm_tick    <= (pwm_next == 9'd0);
            m3step_pulse  <= 1'b0;
            m3cycle_pulse <= 1'b0;
          end else begin
            m3cnt_now     <= reload_m1;
            m3step_idx    <= idx_next;
            m3step_pulse  <= 1'b1;
            m3cycle_pulse <= idx_wrap;
            m3pwm_cnt     <= 9'd0;
            m3pwm_tick    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motoro3_step_timer.sv
// Directed bench for motoro3_step_timer: inputs driven and outputs sampled on
// the falling edge, expected values computed by hand or by simple formulas.
module tb_motoro3_step_timer;

  logic        clk;
  logic        nRst;
  logic [24:0] m3cnt_reload1;
  logic        m3_en;
  logic        m3_dir;
  logic [3:0]  m3step_idx;
  logic        m3step_pulse;
  logic        m3cycle_pulse;
  logic [24:0] m3cnt_now;
  logic [8:0]  m3pwm_cnt;
  logic        m3pwm_tick;
  logic        m3_running;

  int checks   = 0;
  int failures = 0;

  motoro3_step_timer dut (
    .clk           (clk),
    .nRst          (nRst),
    .m3cnt_reload1 (m3cnt_reload1),
    .m3_en         (m3_en),
    .m3_dir        (m3_dir),
    .m3step_idx    (m3step_idx),
    .m3step_pulse  (m3step_pulse),
    .m3cycle_pulse (m3cycle_pulse),
    .m3cnt_now     (m3cnt_now),
    .m3pwm_cnt     (m3pwm_cnt),
    .m3pwm_tick    (m3pwm_tick),
    .m3_running    (m3_running)
  );

  // 10 MHz clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_idx"},   {28'd0, m3step_idx},   32'd0);
    chk({tag, "_pulse"}, {31'd0, m3step_pulse}, 32'd0);
    chk({tag, "_cycle"}, {31'd0, m3cycle_pulse}, 32'd0);
    chk({tag, "_cnt"},   {7'd0, m3cnt_now},     32'd0);
    chk({tag, "_pwm"},   {23'd0, m3pwm_cnt},    32'd0);
    chk({tag, "_tick"},  {31'd0, m3pwm_tick},   32'd0);
    chk({tag, "_run"},   {31'd0, m3_running},   32'd0);
  endtask

  task automatic chk_step(input string tag, input int idx, input int pulse, input int cycle, input int cnt);
    chk({tag, "_idx"},   {28'd0, m3step_idx},    idx);
    chk({tag, "_pulse"}, {31'd0, m3step_pulse},  pulse);
    chk({tag, "_cycle"}, {31'd0, m3cycle_pulse}, cycle);
    chk({tag, "_cnt"},   {7'd0, m3cnt_now},      cnt);
  endtask

  initial begin
    nRst          = 1'b1;
    m3_en         = 1'b0;
    m3_dir        = 1'b1;
    m3cnt_reload1 = 25'd5;
    #5 nRst = 1'b0;
    tick(2);
    chk_zero("reset");
    nRst = 1'b1;
    tick(2);
    chk_zero("idle_after_reset");

    // Forward run, R = 5
    m3_en = 1'b1;
    tick(1);
    chk_step("fwd_start", 0, 1, 0, 4);
    chk("fwd_start_pwm",  {23'd0, m3pwm_cnt}, 0);
    chk("fwd_start_tick", {31'd0, m3pwm_tick}, 1);
    chk("fwd_start_run",  {31'd0, m3_running}, 1);
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      chk_step("fwd", (k / 5) % 12, (k % 5 == 0) ? 1 : 0, (k == 60) ? 1 : 0, 4 - (k % 5));
      chk("fwd_pwm", {23'd0, m3pwm_cnt}, k % 5);
    end

    // Advance to idx 7 with 2 clocks remaining, then stop
    tick(37);
    chk_step("pre_stop", 7, 0, 0, 2);
    m3_en = 1'b0;
    tick(1);
    chk_zero("stopped");
    m3_en = 1'b1;
    tick(1);
    chk_step("restart", 0, 1, 0, 4);
    chk("restart_run", {31'd0, m3_running}, 1);
    tick(4);
    chk_step("restart_end", 0, 0, 0, 0);
    tick(1);
    chk_step("restart_next", 1, 1, 0, 4);

    // Reverse run with reload and direction shadowing
    m3_en = 1'b0;
    tick(1);
    chk_zero("stop_rev");
    m3cnt_reload1 = 25'd4;
    m3_dir = 1'b0;
    m3_en = 1'b1;
    tick(1);
    chk_step("rev_start", 0, 1, 0, 3);
    tick(4);
    chk_step("rev_wrap", 11, 1, 1, 3);
    tick(4);
    chk_step("rev_10", 10, 1, 0, 3);
    tick(1);
    m3cnt_reload1 = 25'd7;
    chk_step("rev_midstep", 10, 0, 0, 2);
    tick(2);
    chk_step("rev_old_len", 10, 0, 0, 0);
    tick(1);
    chk_step("rev_new_load", 9, 1, 0, 6);
    tick(1);
    m3_dir = 1'b1;
    tick(1);
    chk_step("dir_shadow", 9, 0, 0, 4);
    tick(4);
    chk_step("dir_last", 9, 0, 0, 0);
    tick(1);
    chk_step("dir_applied", 10, 1, 0, 6);

    // Clamp of R = 0 and R = 1 to two-clock steps
    m3_en = 1'b0;
    tick(1);
    m3cnt_reload1 = 25'd0;
    m3_en = 1'b1;
    tick(1);
    chk_step("clamp0_a", 0, 1, 0, 1);
    tick(1);
    chk_step("clamp0_b", 0, 0, 0, 0);
    m3cnt_reload1 = 25'd1;
    tick(1);
    chk_step("clamp0_c", 1, 1, 0, 1);
    tick(1);
    chk_step("clamp1_a", 1, 0, 0, 0);
    tick(1);
    chk_step("clamp1_b", 2, 1, 0, 1);

    // pwmSTEP across a 1200-clock step
    m3_en = 1'b0;
    tick(1);
    m3cnt_reload1 = 25'd1200;
    m3_en = 1'b1;
    for (int off = 0; off < 1200; off++) begin
      tick(1);
      chk("pwm_cnt",  {23'd0, m3pwm_cnt}, off % 511);
      chk("pwm_tick", {31'd0, m3pwm_tick}, (off % 511 == 0) ? 1 : 0);
    end
    chk_step("pwm_step_end", 0, 0, 0, 0);
    tick(1);
    chk_step("pwm_boundary", 1, 1, 0, 1199);
    chk("pwm_boundary_cnt",  {23'd0, m3pwm_cnt}, 0);
    chk("pwm_boundary_tick", {31'd0, m3pwm_tick}, 1);

    // Asynchronous reset between edges
    m3cnt_reload1 = 25'd5;
    tick(3);
    @(posedge clk);
    #20 nRst = 1'b0;
    #1 chk_zero("async_rst_now");
    tick(3);
    chk_zero("async_rst_held");
    m3_en = 1'b0;
    nRst = 1'b1;
    tick(3);
    chk_zero("after_release");
    m3_en = 1'b1;
    tick(1);
    chk_step("post_rst_start", 0, 1, 0, 4);
    chk("post_rst_run", {31'd0, m3_running}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motoro3_step_timer.md
# motoro3_step_timer

Step sequencer for the three-phase motor controller. It sits directly downstream of the reload-value register block. It consumes the 25-bit per-step reload count (`m3cnt_reload1`) and divides each electrical period into 12 commutation steps of exactly R clocks each. For every step it produces the step index, a one-clock step-start pulse, a period-wrap pulse and the pwmSTEP sub-counter (511 clocks per pwmSTEP) used by the commutation/PWM stage.

## Interface
- No parameters. Constants: steps per period = 12; pwmSTEP length = 511 clocks.
- `clk`  input  1  system clock, 10 MHz.
- `nRst`  input  1  reset; asynchronous, active-low.
- `m3cnt_reload1`  input  25  step length R in clocks, from the reload register block. Treated as quasi-static.
- `m3_en`  input  1  run enable, level-sensitive.
- `m3_dir`  input  1  1 = forward (index increments), 0 = reverse (index decrements).
- `m3step_idx`  output  4  current step, 0..11.
- `m3step_pulse`  output  1  high for exactly the first clock of every step.
- `m3cycle_pulse`  output  1  high on the first clock of a step whose index wrapped (11→0 forward, 0→11 reverse).
- `m3cnt_now`  output  25  remaining clocks in the current step, R-1 down to 0.
- `m3pwm_cnt`  output  9  pwmSTEP position, 0..510.
- `m3pwm_tick`  output  1  high when `m3pwm_cnt` = 0.
- `m3_running`  output  1  high while in RUN.

## Operation
- Two states, IDLE and RUN. All outputs are registered.
- **Reset (nRst = 0):** state = IDLE. All outputs = 0, including `m3step_idx` = 0 and `m3cnt_now` = 0.
- **Effective reload:** Reff = max(`m3cnt_reload1`, 2). Values 0 and 1 are clamped to 2, so each step is at least 2 clocks long.
- **IDLE:**
  - All outputs held at their reset values.
  - On the edge where `m3_en` = 1: go to RUN, load `m3step_idx` = 0 and `m3cnt_now` = Reff-1, and set `m3step_pulse` = 1, `m3pwm_cnt` = 0, `m3pwm_tick` = 1, `m3running` = 1.
  - `m3cycle_pulse` stays 0 on this start edge.
- **RUN, `m3cnt_now` ≠ 0:**
  - Decrement `m3cnt_now`.
  - `m3pwm_cnt` increments, wrapping 510→0.
  - `m3step_pulse` and `m3cycle_pulse` are 0.
- **RUN, `m3cnt_now` = 0 (step boundary):**
  - Reload `m3cnt_now` = Reff-1, re-sampling `m3cnt_reload1` on this edge only.
  - Advance `m3step_idx` by `m3_dir`, with wrap.
  - `m3step_pulse` = 1; `m3cycle_pulse` = 1 if the index wrapped.
  - `m3pwm_cnt` is forced to 0, so the pwmSTEP restarts at every step.
- **Shadowing:** changes to `m3cnt_reload1` or `m3_dir` mid-step have no effect until the next boundary.
- **`m3_en` = 0 in RUN:** on the next edge, go to IDLE and return all outputs to reset values. A partial step is discarded.
- **Re-enable:** always restarts at step 0 with a full step.
- **`m3_en` toggled 0→1 in consecutive cycles:** behaves as stop followed by a fresh start.
- **Asynchronous reset mid-step:** immediately forces IDLE and reset values, independent of `clk`.

## Timing
- **Start latency:** 1 clock. If `m3_en` is sampled high at edge N, the outputs show step 0 with the pulse asserted after edge N.
- **Step length:** exactly Reff clocks between consecutive rising `m3step_pulse`. A full period is 12·Reff clocks.
- **Pulse width:** `m3step_pulse`, `m3cycle_pulse` and `m3pwm_tick` are each 1 clock wide per event.
- **Stop latency:** 1 clock from `m3_en` sampled low to `m3_running` = 0.
- **Worked example:** Reff = 16 667 gives 200 004 clocks per period, i.e. 20.0004 ms at 10 MHz.

## Test plan
- **Forward run:** reset, then R = 5, `m3_dir` = 1, raise `m3_en`.
  - Required: `m3step_idx` sequence 0..11,0 with 5 clocks per step.
  - Required: `m3step_pulse` every 5 clocks.
  - Required: `m3cycle_pulse` only on the 11→0 transition, 60 clocks after start.
- **Reverse and shadowing:**
  - R = 4, `m3_dir` = 0: required index sequence 0,11,10,….
  - Change R to 7 mid-step: the current step still lasts 4 clocks; the next step lasts 7.
  - Flip `m3_dir` mid-step: takes effect at the next boundary only.
- **Clamp:** R = 0, then R = 1.
  - Required: each step lasts 2 clocks; `m3cnt_now` alternates 1,0.
  - Required: the index advances every 2 clocks.
- **pwmSTEP:** R = 1200.
  - Required: `m3pwm_tick` at step offsets 0, 511 and 1022, then again at the next boundary (offset 0).
  - Required: `m3pwm_cnt` never exceeds 510.
- **Stop/restart:**
  - Drop `m3_en` at idx = 7, `m3cnt_now` = 2: next clock all outputs are 0 and IDLE.
  - Re-raise `m3_en`: idx = 0 with a full step and a pulse after 1 clock.
- **Async reset:** assert `nRst` low between clock edges mid-run.
  - Required: outputs go to 0 before the next edge and stay there while `nRst` is low.
  - Required: after release, no activity until `m3_en` is sampled high.
